stopwatch_counter: RTL and testbench



---
 rtl/stopwatch_counter.sv | 144 ++++++++++++++
 tb/tb_stopwatch_counter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_counter.sv
// MM:SS BCD stopwatch advanced by a synchronized, edge-detected tick from the clock divider.
// Supports run, pause, synchronous clear and a per-field adjust mode.
module stopwatch_counter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_MIN     = 99
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_clr,
  input  logic       i_pause,
  input  logic       i_adj,
  input  logic       i_sel,
  output logic [3:0] o_min_tens,
  output logic [3:0] o_min_ones,
  output logic [3:0] o_sec_tens,
  output logic [3:0] o_sec_ones,
  output logic       o_wrap
);

  localparam logic [3:0] MaxMinTens = 4'(MAX_MIN / 10);
  localparam logic [3:0] MaxMinOnes = 4'(MAX_MIN % 10);

  // Tick synchronizer and rising-edge detector
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   prime_q;
  logic                   prev_q;
  logic                   sync_out;
  logic                   primed;
  logic                   step;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= '0;
      prime_q <= '0;
      prev_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], i_tick};
      prime_q <= {prime_q[SYNC_STAGES-1:0], 1'b1};
      prev_q  <= sync_out;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  // Edge detection is held off until prev_q carries a real sample, so a tick that is
  // already high when reset releases is not mistaken for a rising edge.
  assign primed   = prime_q[SYNC_STAGES];
  assign step     = primed & sync_out & ~prev_q;

  // Count registers
  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic       wrap_q, wrap_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      wrap_q     <= 1'b0;
    end else begin
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      wrap_q     <= wrap_d;
    end
  end

  // BCD incrementers for each field
  logic       sec_at_max;
  logic       min_at_max;
  logic [3:0] sec_tens_inc, sec_ones_inc;
  logic [3:0] min_tens_inc, min_ones_inc;

  assign sec_at_max = (sec_tens_q == 4'd5) && (sec_ones_q == 4'd9);
  assign min_at_max = (min_tens_q == MaxMinTens) && (min_ones_q == MaxMinOnes);

  always_comb begin
    sec_tens_inc = sec_tens_q;
    sec_ones_inc = sec_ones_q + 4'd1;
    if (sec_ones_q >= 4'd9) begin
      sec_ones_inc = 4'd0;
      sec_tens_inc = (sec_tens_q >= 4'd5) ? 4'd0 : sec_tens_q + 4'd1;
    end
  end

  always_comb begin
    min_tens_inc = min_tens_q;
    min_ones_inc = min_ones_q + 4'd1;
    if (min_at_max) begin
      min_tens_inc = 4'd0;
      min_ones_inc = 4'd0;
    end else if (min_ones_q >= 4'd9) begin
      min_ones_inc = 4'd0;
      min_tens_inc = min_tens_q + 4'd1;
    end
  end

  // Next state: clear beats pause, pause beats any step
  always_comb begin
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    wrap_d     = 1'b0;
    if (i_clr) begin
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else if (i_pause) begin
      wrap_d = 1'b0;
    end else if (step) begin
      if (i_adj) begin
        if (i_sel) begin
          sec_tens_d = sec_tens_inc;
          sec_ones_d = sec_ones_inc;
        end else begin
          min_tens_d = min_tens_inc;
          min_ones_d = min_ones_inc;
        end
      end else begin
        sec_tens_d = sec_tens_inc;
        sec_ones_d = sec_ones_inc;
        if (sec_at_max) begin
          min_tens_d = min_tens_inc;
          min_ones_d = min_ones_inc;
          wrap_d     = min_at_max;
        end
      end
    end
  end

  assign o_min_tens = min_tens_q;
  assign o_min_ones = min_ones_q;
  assign o_sec_tens = sec_tens_q;
  assign o_sec_ones = sec_ones_q;
  assign o_wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: two instances (MAX_MIN 99 and 5) checked every cycle against a
// seconds/minutes arithmetic model, plus literal expectations from the test plan.
module tb_stopwatch_counter;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n, tick, clr, pause, adj, sel;
  logic [3:0] mt [2];
  logic [3:0] mo [2];
  logic [3:0] st [2];
  logic [3:0] so [2];
  logic       wr [2];

  always #5 clk = ~clk;

  stopwatch_counter #(.SYNC_STAGES(S), .MAX_MIN(99)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_clr(clr), .i_pause(pause),
    .i_adj(adj), .i_sel(sel), .o_min_tens(mt[0]), .o_min_ones(mo[0]),
    .o_sec_tens(st[0]), .o_sec_ones(so[0]), .o_wrap(wr[0])
  );

  stopwatch_counter #(.SYNC_STAGES(S), .MAX_MIN(5)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tick(tick), .i_clr(clr), .i_pause(pause),
    .i_adj(adj), .i_sel(sel), .o_min_tens(mt[1]), .o_min_ones(mo[1]),
    .o_sec_tens(st[1]), .o_sec_ones(so[1]), .o_wrap(wr[1])
  );

  int checks = 0;
  int failures = 0;
  int maxm [2] = '{99, 5};
  int mdl_mm [2];
  int mdl_ss [2];
  int mdl_wrap [2];
  int wrap_cnt [2];
  bit hist [$];
  int edges;
  bit stp;
  int w0, w1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic lit(input string name, input int idx, input int mm, input int ss);
    chk($sformatf("%s dut%0d min_tens", name, idx), int'(mt[idx]), mm / 10);
    chk($sformatf("%s dut%0d min_ones", name, idx), int'(mo[idx]), mm % 10);
    chk($sformatf("%s dut%0d sec_tens", name, idx), int'(st[idx]), ss / 10);
    chk($sformatf("%s dut%0d sec_ones", name, idx), int'(so[idx]), ss % 10);
  endtask

  // Model: a step is a 0->1 transition of i_tick seen S edges late, only once the
  // synchronizer holds post-reset samples on both sides of the transition.
  initial begin
    edges = 0;
    for (int m = 0; m < 2; m++) begin
      mdl_mm[m] = 0; mdl_ss[m] = 0; mdl_wrap[m] = 0;
    end
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        edges = 0;
        hist.delete();
        for (int m = 0; m < 2; m++) begin
          mdl_mm[m] = 0; mdl_ss[m] = 0; mdl_wrap[m] = 0;
        end
      end else begin
        edges++;
        hist.push_front(tick);
        if (hist.size() > S + 2) void'(hist.pop_back());
        stp = (edges >= S + 2) && hist[S] && !hist[S+1];
        for (int m = 0; m < 2; m++) begin
          mdl_wrap[m] = 0;
          if (clr) begin
            mdl_mm[m] = 0; mdl_ss[m] = 0;
          end else if (!pause && stp) begin
            if (adj) begin
              if (sel) mdl_ss[m] = (mdl_ss[m] + 1) % 60;
              else     mdl_mm[m] = (mdl_mm[m] + 1) % (maxm[m] + 1);
            end else if (mdl_ss[m] == 59) begin
              mdl_ss[m] = 0;
              if (mdl_mm[m] == maxm[m]) begin
                mdl_mm[m] = 0; mdl_wrap[m] = 1;
              end else begin
                mdl_mm[m] = mdl_mm[m] + 1;
              end
            end else begin
              mdl_ss[m] = mdl_ss[m] + 1;
            end
          end
        end
      end
    end
  end

  // Per-cycle compare on the falling edge
  initial begin
    wrap_cnt[0] = 0; wrap_cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        if (!rst_n) begin
          lit("cyc in reset", m, 0, 0);
          chk($sformatf("cyc in reset dut%0d wrap", m), int'(wr[m]), 0);
        end else begin
          lit("cyc", m, mdl_mm[m], mdl_ss[m]);
          chk($sformatf("cyc dut%0d wrap", m), int'(wr[m]), mdl_wrap[m]);
        end
        chk($sformatf("range dut%0d sec_tens", m), int'(st[m] <= 4'd5), 1);
        chk($sformatf("range dut%0d digits", m),
            int'(mt[m] <= 4'd9 && mo[m] <= 4'd9 && so[m] <= 4'd9), 1);
        if (wr[m]) wrap_cnt[m]++;
      end
    end
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(negedge clk); tick = 1'b1;
      repeat (3) @(negedge clk);
      tick = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; clr = 1'b0; pause = 1'b0; adj = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    lit("reset", 0, 0, 0);
    chk("reset wrap", int'(wr[0]), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // First-tick latency: change lands on the third edge after the rise
    tick = 1'b1;
    @(negedge clk); chk("latency edge1 sec_ones", int'(so[0]), 0);
    @(negedge clk); chk("latency edge2 sec_ones", int'(so[0]), 0);
    @(negedge clk); chk("latency edge3 sec_ones", int'(so[0]), 1);
    tick = 1'b0;
    repeat (2) @(negedge clk);
    tick_n(60);
    lit("61 ticks", 0, 1, 1);
    lit("61 ticks", 1, 1, 1);

    // Preload 98:59 and wrap
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0; adj = 1'b1; sel = 1'b0;
    tick_n(98);
    sel = 1'b1;
    tick_n(59);
    lit("preload", 0, 98, 59);
    adj = 1'b0;
    tick_n(1);  lit("run to 99:00", 0, 99, 0);
    tick_n(59); lit("run to 99:59", 0, 99, 59);
    w0 = wrap_cnt[0];
    tick_n(1);
    lit("wrap to 00:00", 0, 0, 0);
    chk("wrap pulse count dut0", wrap_cnt[0] - w0, 1);

    // Adjust fields without carry
    adj = 1'b1; sel = 1'b1;
    tick_n(58); lit("adj sec to 58", 0, 0, 58);
    tick_n(3);  lit("adj sec wrap", 0, 0, 1);
    sel = 1'b0;
    tick_n(99); lit("adj min to 99", 0, 99, 1);
    tick_n(1);  lit("adj min wrap", 0, 0, 1);

    // Pause and clear priority at 05:30
    tick_n(5);
    sel = 1'b1;
    tick_n(29);
    lit("preload 05:30", 0, 5, 30);
    adj = 1'b0; pause = 1'b1;
    tick_n(10); lit("paused", 0, 5, 30);
    pause = 1'b0;
    tick_n(1);  lit("after pause", 0, 5, 31);
    @(negedge clk); clr = 1'b1; pause = 1'b1;
    @(negedge clk); lit("clr over pause", 0, 0, 0);
    tick_n(2);  lit("clr held", 0, 0, 0);
    clr = 1'b0; pause = 1'b0;

    // Held-high tick gives one step
    @(negedge clk); tick = 1'b1;
    repeat (1000) @(negedge clk);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    lit("held tick", 0, 0, 1);

    // Async reset mid-count, release with tick already high
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0; adj = 1'b1; sel = 1'b0;
    tick_n(12);
    sel = 1'b1;
    tick_n(34);
    lit("preload 12:34", 0, 12, 34);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 lit("async reset", 0, 0, 0);
    tick = 1'b1; adj = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    lit("release tick high", 0, 0, 0);
    tick = 1'b0;
    repeat (4) @(negedge clk);
    tick_n(1);
    lit("first tick after release", 0, 0, 1);

    // MAX_MIN=5 instance wraps at 05:59, then full sweep
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0; adj = 1'b1; sel = 1'b0;
    tick_n(5);
    sel = 1'b1;
    tick_n(59);
    lit("preload 05:59", 1, 5, 59);
    lit("preload 05:59", 0, 5, 59);
    adj = 1'b0;
    w0 = wrap_cnt[0]; w1 = wrap_cnt[1];
    tick_n(1);
    lit("max5 wrap", 1, 0, 0);
    lit("max99 no wrap", 0, 6, 0);
    chk("wrap pulse count dut1", wrap_cnt[1] - w1, 1);
    chk("no wrap dut0", wrap_cnt[0] - w0, 0);
    w1 = wrap_cnt[1];
    tick_n(360);
    lit("sweep end", 1, 0, 0);
    lit("sweep end", 0, 12, 0);
    chk("sweep wrap count dut1", wrap_cnt[1] - w1, 1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
